dmem_port_arbiter: RTL

//  Shares the single data-memory port of mips_16 between two requesters: the CPU load/store path
//  (req 0) and the debug/program-loader port (req 1). Round-robin arbitration, one access in flight,

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/rr_arb2.sv | 15 +
 rtl/dmem_port_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the mips_16 data-memory port arbiter: FSM states,
// requester identifiers and the supported memory-latency range.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;
  localparam int LAT_W       = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that did not win last time.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_win,
  output logic       o_any
);

  assign o_any = |i_req;
  assign o_win = (&i_req) ? ~i_last : i_req[REQ_DBG];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the mips_16 data-memory port between the CPU load/store path and the
// debug/loader port; one access in flight, fixed read latency MEM_LAT.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              misalign
);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("dmem_port_arbiter: MEM_LAT must be within 1..15");
  end

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic              r_win;
  logic              r_we;
  logic              r_last;
  logic [1:0]        w_req;
  logic              w_win;
  logic              w_any;
  logic              w_grant;
  logic              w_mem_done;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  assign w_req = {dbg_req, cpu_req};

  rr_arb2 u_rr_arb2 (
    .i_req  (w_req),
    .i_last (r_last),
    .o_win  (w_win),
    .o_any  (w_any)
  );

  // The DONE cycle also arbitrates so back-to-back accesses need no idle bubble.
  assign w_grant    = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && w_any;
  assign w_mem_done = (r_state == ST_BUSY) && (r_lat_cnt == '0);

  assign w_we    = (w_win == REQ_DBG) ? dbg_we    : cpu_we;
  assign w_addr  = (w_win == REQ_DBG) ? dbg_addr  : cpu_addr;
  assign w_wdata = (w_win == REQ_DBG) ? dbg_wdata : cpu_wdata;

  assign cpu_stall = cpu_req & ~cpu_rvalid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_lat_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_lat_cnt <= LAT_W'(MEM_LAT);
      end else if ((r_state == ST_BUSY) && (r_lat_cnt != '0)) begin
        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: w_state_nxt = w_any ? ST_BUSY : ST_IDLE;
      ST_BUSY:          if (r_lat_cnt == '0) w_state_nxt = ST_DONE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      misalign   <= 1'b0;
      r_win      <= REQ_CPU;
      r_we       <= 1'b0;
      r_last     <= REQ_DBG;
    end else begin
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      misalign   <= 1'b0;
      if (w_grant) begin
        cpu_gnt   <= (w_win == REQ_CPU);
        dbg_gnt   <= (w_win == REQ_DBG);
        mem_en    <= 1'b1;
        mem_we    <= w_we;
        mem_addr  <= w_addr[ADDR_W-1:1];
        mem_wdata <= w_wdata;
        misalign  <= w_addr[0];
        r_win     <= w_win;
        r_we      <= w_we;
        r_last    <= w_win;
      end
      // Stores complete with zero read data so a stale load value never leaks out.
      if (w_mem_done) begin
        if (r_win == REQ_CPU) begin
          cpu_rvalid <= 1'b1;
          cpu_rdata  <= r_we ? '0 : mem_rdata;
        end else begin
          dbg_rvalid <= 1'b1;
          dbg_rdata  <= r_we ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule
